// File: rtl/float_acc_ctrl.sv
// Initiator-side accumulator controller for a STB/ACK float adder: sums P_LEN samples per output.
// Optional sticky inf/NaN flag on o_INF is enabled with `define FLOAT_ACC_INF_FLAG_EN.
module float_acc_ctrl #(
    parameter int unsigned P_LEN   = 8,
    parameter int unsigned P_CNT_W = 4
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [31:0] i_DATA,
    input  logic        i_DATA_STB,
    output logic        o_DATA_ACK,
    output logic [31:0] o_A,
    output logic [31:0] o_B,
    output logic        o_AB_STB,
    input  logic        i_AB_ACK,
    input  logic [31:0] i_Z,
    input  logic        i_Z_STB,
    output logic        o_Z_ACK,
    output logic [31:0] o_SUM,
    output logic        o_SUM_STB,
    input  logic        i_SUM_ACK,
    output logic        o_INF
);

    localparam logic [1:0] S_GET  = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [P_CNT_W-1:0] CNT_LAST = P_CNT_W'(P_LEN - 1);

    logic [1:0]         state;
    logic [31:0]        r_acc;
    logic [31:0]        r_b;
    logic [P_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state <= S_GET;
            r_acc <= 32'h0000_0000;
            r_b   <= 32'h0000_0000;
            r_cnt <= '0;
        end else begin
            case (state)
                S_GET: begin
                    if (i_DATA_STB) begin
                        r_b   <= i_DATA;
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_AB_ACK) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_Z_STB) begin
                        r_acc <= i_Z;
                        // Counter parks on the last index while the sum is held in S_OUT.
                        if (r_cnt == CNT_LAST) begin
                            state <= S_OUT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            state <= S_GET;
                        end
                    end
                end
                default: begin
                    if (i_SUM_ACK) begin
                        r_acc <= 32'h0000_0000;
                        r_cnt <= '0;
                        state <= S_GET;
                    end
                end
            endcase
        end
    end

    // Handshake outputs decode straight from the state register.
    assign o_DATA_ACK = (state == S_GET);
    assign o_AB_STB   = (state == S_REQ);
    assign o_Z_ACK    = (state == S_WAIT);
    assign o_SUM_STB  = (state == S_OUT);
    assign o_A        = r_acc;
    assign o_B        = r_b;
    assign o_SUM      = r_acc;

`ifdef FLOAT_ACC_INF_FLAG_EN
    logic r_inf;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_inf <= 1'b0;
        end else if ((state == S_WAIT) && i_Z_STB && (i_Z[30:23] == 8'hFF)) begin
            r_inf <= 1'b1;
        end else if ((state == S_OUT) && i_SUM_ACK) begin
            r_inf <= 1'b0;
        end
    end

    assign o_INF = r_inf;
`else
    assign o_INF = 1'b0;
`endif

endmodule

// File: tb/tb_float_acc_ctrl.sv
// Scoreboard bench for float_acc_ctrl: random samples, a stub adder with random stalls,
// and a sum sink with random backpressure, checked against a group-sum reference model.
`timescale 1ns/1ps
module tb_float_acc_ctrl;

    localparam int unsigned P_LEN = 8;
`ifdef FLOAT_ACC_INF_FLAG_EN
    localparam bit INF_EN = 1'b1;
`else
    localparam bit INF_EN = 1'b0;
`endif

    logic        i_CLK = 1'b0;
    logic        i_RST = 1'b1;
    logic [31:0] i_DATA = '0;
    logic        i_DATA_STB = 1'b0;
    logic        o_DATA_ACK;
    logic [31:0] o_A;
    logic [31:0] o_B;
    logic        o_AB_STB;
    logic        i_AB_ACK = 1'b0;
    logic [31:0] i_Z = '0;
    logic        i_Z_STB = 1'b0;
    logic        o_Z_ACK;
    logic [31:0] o_SUM;
    logic        o_SUM_STB;
    logic        i_SUM_ACK = 1'b0;
    logic        o_INF;

    float_acc_ctrl #(.P_LEN(P_LEN), .P_CNT_W(4)) dut (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_DATA     (i_DATA),
        .i_DATA_STB (i_DATA_STB),
        .o_DATA_ACK (o_DATA_ACK),
        .o_A        (o_A),
        .o_B        (o_B),
        .o_AB_STB   (o_AB_STB),
        .i_AB_ACK   (i_AB_ACK),
        .i_Z        (i_Z),
        .i_Z_STB    (i_Z_STB),
        .o_Z_ACK    (o_Z_ACK),
        .o_SUM      (o_SUM),
        .o_SUM_STB  (o_SUM_STB),
        .i_SUM_ACK  (i_SUM_ACK),
        .o_INF      (o_INF)
    );

    always #5 i_CLK = ~i_CLK;

    int total = 0;
    int bad   = 0;

    // Expected operand pairs per sample and expected completed sums.
    logic [31:0] op_a_q[$];
    logic [31:0] op_b_q[$];
    logic [31:0] sum_q[$];
    logic        inf_q[$];
    logic [31:0] m_acc = '0;
    int          m_cnt = 0;
    logic        m_inf = 1'b0;
    bit          abort = 1'b1;
    int          n_req = 0;
    int          sums_seen = 0;

    // Stand-in adder: any deterministic function proves the controller forwards bits unchanged.
    function automatic logic [31:0] add_fn(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge i_CLK);
        #1;
    endtask

    task automatic model_push(input logic [31:0] s);
        op_a_q.push_back(m_acc);
        op_b_q.push_back(s);
        m_acc = add_fn(m_acc, s);
        if (m_acc[30:23] == 8'hFF) m_inf = 1'b1;
        m_cnt++;
        if (m_cnt == P_LEN) begin
            sum_q.push_back(m_acc);
            inf_q.push_back(INF_EN ? m_inf : 1'b0);
            m_acc = '0;
            m_cnt = 0;
            m_inf = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] s, input int gap);
        int w = 0;
        i_DATA     = s;
        i_DATA_STB = 1'b1;
        while (!o_DATA_ACK && w < 300) begin
            tick();
            w++;
        end
        if (!o_DATA_ACK) begin
            chk("data_ack_timeout", {31'd0, o_DATA_ACK}, 32'd1);
            i_DATA_STB = 1'b0;
        end else begin
            model_push(s);
            tick();
            i_DATA_STB = 1'b0;
            i_DATA     = $urandom;
            chk("req_latency", {31'd0, o_AB_STB}, 32'd1);
            repeat (gap) tick();
        end
    endtask

    task automatic wait_drained(input int budget);
        int w = 0;
        while ((sum_q.size() != 0 || op_a_q.size() != 0) && w < budget) begin
            tick();
            w++;
        end
        chk("drain_timeout", sum_q.size() + op_a_q.size(), 32'd0);
    endtask

    // Stub adder with stalls and spurious strobes outside its open handshakes.
    int          st = 0;
    int          acnt = 0;
    int          zcnt = 0;
    logic [31:0] za, zb, zr;
    initial begin
        forever begin
            tick();
            if (abort) begin
                st = 0;
                i_AB_ACK = 1'b0;
                i_Z_STB  = 1'b0;
            end else begin
                case (st)
                    0: begin
                        if (o_AB_STB) begin
                            za = o_A;
                            zb = o_B;
                            acnt = (n_req < 2) ? 5 : $urandom_range(0, 3);
                            i_Z_STB  = 1'b0;
                            i_AB_ACK = (acnt == 0);
                            st = 1;
                        end else if (!o_Z_ACK) begin
                            i_Z_STB  = ($urandom_range(0, 3) == 0);
                            i_AB_ACK = ($urandom_range(0, 3) == 0);
                            i_Z      = $urandom;
                        end else begin
                            chk("stub_unexpected_z_ack", {31'd0, o_Z_ACK}, 32'd0);
                        end
                    end
                    1: begin
                        if (i_AB_ACK) begin
                            i_AB_ACK = 1'b0;
                            chk("ab_stb_drop", {31'd0, o_AB_STB}, 32'd0);
                            if (op_a_q.size() == 0) begin
                                chk("unexpected_request", 32'd1, 32'd0);
                            end else begin
                                chk("operand_a", za, op_a_q.pop_front());
                                chk("operand_b", zb, op_b_q.pop_front());
                            end
                            zr   = add_fn(za, zb);
                            zcnt = (n_req < 2) ? 7 : $urandom_range(0, 3);
                            n_req++;
                            if (zcnt == 0) begin
                                i_Z     = zr;
                                i_Z_STB = 1'b1;
                            end
                            st = 2;
                        end else begin
                            chk("a_stable", o_A, za);
                            chk("b_stable", o_B, zb);
                            chk("ab_stb_hold", {31'd0, o_AB_STB}, 32'd1);
                            acnt--;
                            i_AB_ACK = (acnt == 0);
                        end
                    end
                    default: begin
                        if (i_Z_STB) begin
                            i_Z_STB  = 1'b0;
                            i_AB_ACK = 1'b0;
                            chk("post_z_state", {31'd0, o_DATA_ACK | o_SUM_STB}, 32'd1);
                            st = 0;
                        end else begin
                            chk("z_ack_hold", {31'd0, o_Z_ACK}, 32'd1);
                            i_AB_ACK = $urandom_range(0, 1);
                            zcnt--;
                            if (zcnt == 0) begin
                                i_Z     = zr;
                                i_Z_STB = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Sum sink: the first sum is held off for 20 cycles, later ones randomly.
    int          hold = 0;
    bit          seen = 1'b0;
    bit          acked = 1'b0;
    logic [31:0] held_sum;
    initial begin
        forever begin
            tick();
            if (abort) begin
                i_SUM_ACK = 1'b0;
                seen  = 1'b0;
                acked = 1'b0;
            end else if (acked) begin
                acked = 1'b0;
                seen  = 1'b0;
                chk("data_ack_after_sum", {31'd0, o_DATA_ACK}, 32'd1);
                chk("sum_stb_drop", {31'd0, o_SUM_STB}, 32'd0);
                chk("inf_clear", {31'd0, o_INF}, 32'd0);
                i_SUM_ACK = $urandom_range(0, 1);
            end else if (o_SUM_STB) begin
                if (!seen) begin
                    seen     = 1'b1;
                    held_sum = o_SUM;
                    hold     = (sums_seen == 0) ? 20 : $urandom_range(0, 4);
                end else begin
                    chk("sum_stable", o_SUM, held_sum);
                    chk("data_ack_blocked", {31'd0, o_DATA_ACK}, 32'd0);
                    hold--;
                end
                if (hold <= 0) begin
                    i_SUM_ACK = 1'b1;
                    acked     = 1'b1;
                    sums_seen++;
                    if (sum_q.size() == 0) begin
                        chk("unexpected_sum", 32'd1, 32'd0);
                    end else begin
                        chk("sum_value", o_SUM, sum_q.pop_front());
                        chk("inf_flag", {31'd0, o_INF}, {31'd0, inf_q.pop_front()});
                    end
                end else begin
                    i_SUM_ACK = 1'b0;
                end
            end else begin
                i_SUM_ACK = $urandom_range(0, 1);
            end
        end
    end

    // Exactly one handshake is open every cycle.
    initial begin
        forever begin
            tick();
            if (!abort) begin
                chk("one_open", $countones({o_DATA_ACK, o_AB_STB, o_Z_ACK, o_SUM_STB}), 32'd1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    logic [31:0] grp[8];
    initial begin
        repeat (3) tick();
        chk("rst_data_ack", {31'd0, o_DATA_ACK}, 32'd1);
        chk("rst_ab_stb", {31'd0, o_AB_STB}, 32'd0);
        chk("rst_z_ack", {31'd0, o_Z_ACK}, 32'd0);
        chk("rst_sum_stb", {31'd0, o_SUM_STB}, 32'd0);
        chk("rst_a", o_A, 32'd0);
        chk("rst_b", o_B, 32'd0);
        chk("rst_sum", o_SUM, 32'd0);
        chk("rst_inf", {31'd0, o_INF}, 32'd0);
        i_RST = 1'b0;
        abort = 1'b0;

        repeat (8) send(32'h3F80_0000, 0);
        grp = '{32'h3F80_0000, 32'h4000_0000, 32'hC040_0000, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) send(grp[i], $urandom_range(0, 2));
        repeat (8) send(32'h4000_0000, 0);
        grp = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) send(grp[i], 0);
        send(32'h7F80_0000, 0);
        repeat (7) send(32'h0000_0000, 1);
        wait_drained(2000);

        // Abandon a partial group from S_WAIT with a reset.
        repeat (3) send(32'h3F80_0000, 0);
        for (int w = 0; w < 100 && !o_Z_ACK; w++) tick();
        chk("reach_wait", {31'd0, o_Z_ACK}, 32'd1);
        abort = 1'b1;
        i_RST = 1'b1;
        tick();
        i_RST = 1'b0;
        chk("mid_rst_data_ack", {31'd0, o_DATA_ACK}, 32'd1);
        chk("mid_rst_stbs", {29'd0, o_AB_STB, o_Z_ACK, o_SUM_STB}, 32'd0);
        chk("mid_rst_acc", o_A, 32'd0);
        repeat (2) tick();
        op_a_q.delete();
        op_b_q.delete();
        sum_q.delete();
        inf_q.delete();
        m_acc = '0;
        m_cnt = 0;
        m_inf = 1'b0;
        abort = 1'b0;

        repeat (8) send(32'h3F80_0000, 0);
        for (int g = 0; g < 12; g++) begin
            for (int i = 0; i < 8; i++) begin
                send(($urandom_range(0, 7) == 0) ? 32'h7F80_0000 : $urandom,
                     $urandom_range(0, 3));
            end
        end
        wait_drained(3000);
        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
